// File: rtl/mc_controller.sv
// Multicycle control unit for the 4-bit CPU: sequences fetch/decode/execute/memory/writeback,
// drives every datapath enable and mux select, and stalls on the single-ready memory handshake.
module mc_controller #(
  parameter int OPW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alucontrol,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic        pcen,
  output logic        irwrite,
  output logic        iord,
  output logic        mem_req,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    ALUWB  = 4'd3,
    IMMEX  = 4'd4,
    MEMADR = 4'd5,
    MEMRD  = 4'd6,
    MEMWB  = 4'd7,
    MEMWR  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    HALT   = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] opc;
  logic       unused_instr;

  assign opc          = 4'(instr[15 -: OPW]);
  assign unused_instr = ^instr[15-OPW:0];
  assign state        = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Memory handshake: mem_req is held with a stable iord until the cycle mem_ready is high;
  // that cycle completes the access and the state advances on the following edge.
  always_comb begin
    state_d    = state_q;
    alucontrol = 4'd0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    halted     = 1'b0;
    // Reset silences every strobe combinationally so an aborted instruction leaves no pulse.
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcen    = mem_ready;
          if (mem_ready) state_d = DECODE;
        end
        DECODE: begin
          alusrcb = 2'b10;
          case (opc)
            4'hA:       state_d = IMMEX;
            4'hB, 4'hC: state_d = MEMADR;
            4'hD:       state_d = BRANCH;
            4'hE:       state_d = JUMP;
            4'hF:       state_d = HALT;
            default:    state_d = EXEC;
          endcase
        end
        EXEC: begin
          alusrca    = 1'b1;
          alucontrol = opc;
          state_d    = ALUWB;
        end
        ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          state_d  = FETCH;
        end
        IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          state_d = ALUWB;
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          state_d = (opc == 4'hC) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = MEMWB;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          state_d  = FETCH;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          memwrite = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_d = FETCH;
        end
        BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = 4'd1;
          pcsrc      = 2'b01;
          pcen       = zero;
          state_d    = FETCH;
        end
        JUMP: begin
          pcsrc   = 2'b10;
          pcen    = 1'b1;
          state_d = FETCH;
        end
        HALT: begin
          halted  = 1'b1;
          state_d = HALT;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a table of per-cycle {inputs, expected outputs} records
// plus hand-written sequences for HALT persistence and asynchronous reset aborts.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [3:0]  alucontrol;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic        pcen, irwrite, iord, mem_req, memwrite, regwrite, regdst, memtoreg, halted;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_controller #(.OPW(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .mem_req(mem_req), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .halted(halted), .state(state)
  );

  // {state, alucontrol, alusrca, alusrcb, pcsrc, pcen, irwrite, iord, mem_req,
  //  memwrite, regwrite, regdst, memtoreg, halted}
  logic [21:0] obs;
  assign obs = {state, alucontrol, alusrca, alusrcb, pcsrc, pcen, irwrite, iord, mem_req,
                memwrite, regwrite, regdst, memtoreg, halted};

  function automatic logic [21:0] pk(int st, int alu, int asa, int asb, int pcs, int pen,
                                     int irw, int io, int mreq, int mw, int rw, int rd,
                                     int m2r, int h);
    return {4'(st), 4'(alu), 1'(asa), 2'(asb), 2'(pcs), 1'(pen), 1'(irw), 1'(io), 1'(mreq),
            1'(mw), 1'(rw), 1'(rd), 1'(m2r), 1'(h)};
  endfunction

  typedef struct {
    string       tag;
    logic        rst;
    logic [3:0]  op;
    logic        z;
    logic        mr;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string tag, input logic rst, input logic [3:0] op, input logic z,
                     input logic mr, input logic [21:0] exp);
    vec_t v;
    v.tag = tag; v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic [21:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %06h required %06h (state got %0d)", tag, obs, exp, state);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, check mid-low-phase before the rising edge.
  task automatic step(input string tag, input logic rst, input logic [3:0] op, input logic z,
                      input logic mr, input logic [21:0] exp);
    @(negedge clk);
    reset = rst; instr = {op, 12'h5A3}; zero = z; mem_ready = mr;
    #2;
    check(tag, exp);
  endtask

  logic [21:0] zs, f_stall, f_go, dec;

  initial begin
    zs      = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    f_stall = pk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    f_go    = pk(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    dec     = pk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("reset",        1, 4'h0, 0, 1, zs);
    // ADD, no stalls
    add("add_fetch",    0, 4'h0, 0, 1, f_go);
    add("add_decode",   0, 4'h0, 0, 1, dec);
    add("add_exec",     0, 4'h0, 0, 1, pk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("add_aluwb",    0, 4'h0, 0, 1, pk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // LSR with two FETCH stall cycles
    add("lsr_stall1",   0, 4'h9, 0, 0, f_stall);
    add("lsr_stall2",   0, 4'h9, 0, 0, f_stall);
    add("lsr_fetch",    0, 4'h9, 0, 1, f_go);
    add("lsr_decode",   0, 4'h9, 0, 1, dec);
    add("lsr_exec",     0, 4'h9, 0, 1, pk(2, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lsr_aluwb",    0, 4'h9, 0, 1, pk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // LW with three MEMRD stall cycles
    add("lw_fetch",     0, 4'hB, 0, 1, f_go);
    add("lw_decode",    0, 4'hB, 0, 1, dec);
    add("lw_memadr",    0, 4'hB, 0, 1, pk(5, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lw_rd_stall1", 0, 4'hB, 0, 0, pk(6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    add("lw_rd_stall2", 0, 4'hB, 0, 0, pk(6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    add("lw_rd_stall3", 0, 4'hB, 0, 0, pk(6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    add("lw_rd_done",   0, 4'hB, 0, 1, pk(6, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    add("lw_memwb",     0, 4'hB, 0, 1, pk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    // ADDI
    add("addi_fetch",   0, 4'hA, 0, 1, f_go);
    add("addi_decode",  0, 4'hA, 0, 1, dec);
    add("addi_immex",   0, 4'hA, 0, 1, pk(4, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("addi_aluwb",   0, 4'hA, 0, 1, pk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // SW with one MEMWR stall cycle
    add("sw_fetch",     0, 4'hC, 0, 1, f_go);
    add("sw_decode",    0, 4'hC, 0, 1, dec);
    add("sw_memadr",    0, 4'hC, 0, 1, pk(5, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("sw_wr_stall",  0, 4'hC, 0, 0, pk(8, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    add("sw_wr_done",   0, 4'hC, 0, 1, pk(8, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    // BEQ taken, then not taken
    add("beq1_fetch",   0, 4'hD, 1, 1, f_go);
    add("beq1_decode",  0, 4'hD, 1, 1, dec);
    add("beq1_branch",  0, 4'hD, 1, 1, pk(9, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("beq0_fetch",   0, 4'hD, 0, 1, f_go);
    add("beq0_decode",  0, 4'hD, 0, 1, dec);
    add("beq0_branch",  0, 4'hD, 0, 1, pk(9, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // J
    add("j_fetch",      0, 4'hE, 0, 1, f_go);
    add("j_decode",     0, 4'hE, 0, 1, dec);
    add("j_jump",       0, 4'hE, 0, 1, pk(10, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // HALT
    add("halt_fetch",   0, 4'hF, 0, 1, f_go);
    add("halt_decode",  0, 4'hF, 0, 1, dec);
    add("halt_enter",   0, 4'hF, 0, 1, pk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) step(vecs[i].tag, vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr,
                           vecs[i].exp);

    // HALT must persist regardless of handshake inputs.
    for (int i = 0; i < 20; i++)
      step($sformatf("halt_hold%0d", i), 0, 4'(i), 1'(i), 1'(i >> 1),
           pk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Asynchronous reset mid-cycle out of HALT.
    #1 reset = 1'b1;
    #1 check("halt_async_reset", zs);
    step("halt_reset_hold", 1, 4'hF, 0, 1, zs);

    // Reset asserted mid-cycle during a stalled MEMWR.
    step("sw2_fetch",   0, 4'hC, 0, 1, f_go);
    step("sw2_decode",  0, 4'hC, 0, 1, dec);
    step("sw2_memadr",  0, 4'hC, 0, 1, pk(5, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("sw2_wr_stall", 0, 4'hC, 0, 0, pk(8, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    #1 reset = 1'b1;
    #1 check("memwr_async_reset", zs);
    step("memwr_reset_hold", 1, 4'hC, 1, 1, zs);
    step("post_reset_fetch", 0, 4'h0, 0, 0, f_stall);
    step("post_reset_go",    0, 4'h0, 0, 1, f_go);
    step("post_reset_dec",   0, 4'h0, 0, 1, dec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the 4-bit CPU datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It is the producer of the `alucontrol` code consumed by the ALU, and it receives the ALU `zero` flag back for branch resolution. It also drives every datapath enable and mux select, and it stalls on a single-ready memory handshake.

## Interface
- `OPW`, default 4: opcode field width, `instr[15:12]`.
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high. Forces state FETCH and all strobes low immediately.
- `instr`: input, 16 bits. Instruction register contents. Only `[15:12]` (opcode) is used.
- `zero`: input, 1 bit. ALU zero flag, sampled in BRANCH.
- `mem_ready`: input, 1 bit. Memory completes the current access this cycle.
- `alucontrol`: output, 4 bits. ALU operation code. 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 div, 7 slt, 8 lsl, 9 lsr.
- `alusrca`: output, 1 bit. ALU A select: 0 = PC, 1 = register A.
- `alusrcb`: output, 2 bits. ALU B select: 00 = register B, 01 = constant 1, 10 = sign-extended imm4.
- `pcsrc`: output, 2 bits. PC select: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `pcen`: output, 1 bit. PC write enable.
- `irwrite`: output, 1 bit. Instruction register load.
- `iord`: output, 1 bit. Memory address select: 0 = PC, 1 = ALUOut.
- `mem_req`: output, 1 bit. Memory access request.
- `memwrite`: output, 1 bit. Write qualifier for `mem_req`.
- `regwrite`: output, 1 bit. Register file write.
- `regdst`: output, 1 bit. Register destination select (rd field).
- `memtoreg`: output, 1 bit. Writeback data select: 0 = ALUOut, 1 = memory data.
- `halted`: output, 1 bit. High in HALT.
- `state`: output, 4 bits. Current state encoding, for debug.

## Operation
- Opcodes: 0x0–0x9 are R-type, with `alucontrol` equal to the opcode. 0xA ADDI, 0xB LW, 0xC SW, 0xD BEQ, 0xE J, 0xF HALT. All 16 opcodes are defined.
- State encodings: FETCH=0, DECODE=1, EXEC=2, ALUWB=3, IMMEX=4, MEMADR=5, MEMRD=6, MEMWB=7, MEMWR=8, BRANCH=9, JUMP=10, HALT=11. Encodings 12–15 are illegal and return to FETCH on the next edge.
- FETCH:
  - Asserts `mem_req=1`, `iord=0`, `alusrca=0`, `alusrcb=01`, `alucontrol=0`, `pcsrc=00`.
  - `irwrite` and `pcen` are `mem_ready`-qualified: both are 1 only in the cycle `mem_ready=1`.
  - Holds in FETCH while `mem_ready=0`. Goes to DECODE when `mem_ready=1`.
- DECODE:
  - Asserts `alusrca=0`, `alusrcb=10`, `alucontrol=0`. This precomputes the branch target PC+imm into ALUOut.
  - Next state by opcode: 0–9 → EXEC; A → IMMEX; B/C → MEMADR; D → BRANCH; E → JUMP; F → HALT.
- EXEC: `alusrca=1`, `alusrcb=00`, `alucontrol=opcode`. Next state ALUWB.
- ALUWB: `regwrite=1`, `regdst=1`, `memtoreg=0`. Next state FETCH.
- IMMEX: `alusrca=1`, `alusrcb=10`, `alucontrol=0`. Next state ALUWB.
- MEMADR: same datapath controls as IMMEX. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: `mem_req=1`, `iord=1`. Holds while `mem_ready=0`. Goes to MEMWB when `mem_ready=1`.
- MEMWB: `regwrite=1`, `memtoreg=1`. Next state FETCH.
- MEMWR: `mem_req=1`, `memwrite=1`, `iord=1`. Holds while `mem_ready=0`. Goes to FETCH when `mem_ready=1`.
- BRANCH:
  - Drives `alusrca=1`, `alusrcb=00`, `alucontrol=1` (sub) and `pcsrc=01`.
  - `pcen` equals `zero`: taken if equal, otherwise PC keeps PC+1.
  - Next state FETCH.
- JUMP: `pcsrc=10`, `pcen=1`. Next state FETCH.
- HALT: `halted=1`, all strobes 0. Stays in HALT until reset.
- Default output values: any output not listed for a state is 0, and `alucontrol` is 0.

## Timing
- All outputs are Moore functions of `state`, with three exceptions: FETCH `irwrite` and `pcen` (qualified by `mem_ready`) and BRANCH `pcen` (equal to `zero`). These are combinational from inputs in the same cycle.
- Instruction latency with `mem_ready` tied high: R-type 4 cycles, ADDI 4, LW 5, SW 4, BEQ 3, J 3, HALT reached in 3 cycles.
- Each low cycle of `mem_ready` during FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_req` stays high and the address select stays stable for the whole stall.
- Reset behaviour:
  - Reset asserted: `state=0`, and every output is 0, including `alucontrol`, `halted` and `mem_req`. The FETCH `mem_req` assertion begins only after reset is released.
  - Reset asserted mid-instruction, including during a stall or in HALT, aborts the instruction with no partial `regwrite` or `pcen`.
  - Reset release: the first FETCH is on the first rising edge after deassertion.

## Test plan
- ADD with `mem_ready=1` (opcode 0x0): states 0→1→2→3→0. `alucontrol=0` in EXEC, `regwrite=1` only in ALUWB.
- LSR (opcode 0x9) with `mem_ready` low for 2 cycles in FETCH: FETCH lasts 3 cycles. `irwrite` and `pcen` pulse once, in the third cycle. `alucontrol=9` in EXEC.
- LW with `mem_ready` low for 3 cycles in MEMRD: states 0,1,5,6,6,6,6,7. `iord=1` throughout MEMRD. `memtoreg=1` and `regwrite=1` in MEMWB.
- BEQ: with `zero=1`, `pcen=1` and `pcsrc=01` in BRANCH. With `zero=0`, `pcen=0`. Both cases return to FETCH next cycle.
- HALT (0xF): `halted=1` persists for 20 cycles. Then reset is asserted asynchronously mid-cycle: `state=0` and `halted=0` before the next edge.
- Reset asserted during MEMWR: `memwrite` and `mem_req` drop immediately, and no `regwrite` or `pcen` pulse occurs.
